tx_iq_feed: RTL and testbench

TX_IQ_FEED -- requirements
Module: tx_iq_feed

---
 rtl/tx_iq_feed.sv | 152 +++++++++++++++
 tb/tb_tx_iq_feed.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_iq_feed.sv
// I/Q sample FIFO between the host write port and the TX serializer.
// Gates do_tx through a prefill/run/drain sequence and tracks under/overflow.
module tx_iq_feed #(
  parameter int DEPTH_LOG2 = 4,
  parameter int PREFILL    = 8
) (
  input  logic                  rx_clk,
  input  logic                  rst_ddr,
  input  logic                  tx_enable,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [12:0]           wr_i,
  input  logic [12:0]           wr_q,
  output logic                  wr_full,
  output logic [DEPTH_LOG2:0]   wr_level,
  input  logic                  next_data,
  output logic [12:0]           data_i,
  output logic [12:0]           data_q,
  output logic                  do_tx,
  output logic                  underflow,
  output logic                  overflow,
  output logic [7:0]            underflow_cnt
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef struct packed {
    logic [12:0] i;
    logic [12:0] q;
  } iq_t;

  typedef enum logic [1:0] {S_IDLE, S_PREFILL, S_RUN, S_DRAIN} state_t;

  state_t                state;
  iq_t                   mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic [1:0]            nd_pipe;
  logic                  consume, empty, full, pop, push;
  iq_t                   head;

  // nd_pipe[0] is next_data registered, nd_pipe[1] the cycle before it
  assign consume  = nd_pipe[0] & ~nd_pipe[1];
  assign empty    = (level == '0);
  assign full     = (level == (DEPTH_LOG2+1)'(DEPTH));
  assign head     = mem[rd_ptr];
  assign wr_full  = full;
  assign wr_level = level;

  always_comb begin
    pop = 1'b0;
    case (state)
      S_PREFILL:      pop = tx_enable && (level >= (DEPTH_LOG2+1)'(PREFILL));
      S_RUN, S_DRAIN: pop = consume && !empty;
      default:        pop = 1'b0;
    endcase
    if (flush) pop = 1'b0;
  end

  // A pop in the same cycle frees the slot, so a write into a full FIFO is kept
  assign push = wr_en && !flush && (!full || pop);

  always_ff @(posedge rx_clk) begin
    if (push) mem[wr_ptr] <= '{i: wr_i, q: wr_q};
  end

  always_ff @(posedge rx_clk or negedge rst_ddr) begin
    if (!rst_ddr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      nd_pipe <= '0;
    end else begin
      nd_pipe <= {nd_pipe[0], next_data};
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge rx_clk or negedge rst_ddr) begin
    if (!rst_ddr) begin
      state         <= S_IDLE;
      data_i        <= '0;
      data_q        <= '0;
      do_tx         <= 1'b0;
      underflow     <= 1'b0;
      overflow      <= 1'b0;
      underflow_cnt <= '0;
    end else if (flush) begin
      state         <= S_IDLE;
      data_i        <= '0;
      data_q        <= '0;
      do_tx         <= 1'b0;
      underflow     <= 1'b0;
      overflow      <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      if (wr_en && full && !pop) overflow <= 1'b1;
      case (state)
        S_IDLE: if (tx_enable) state <= S_PREFILL;
        S_PREFILL: begin
          if (!tx_enable) state <= S_IDLE;
          else if (pop) begin
            data_i <= head.i;
            data_q <= head.q;
            do_tx  <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (consume) begin
            if (pop) begin
              data_i <= head.i;
              data_q <= head.q;
            end else begin
              // Keep the serializer running on zeros and record the starvation
              data_i    <= '0;
              data_q    <= '0;
              underflow <= 1'b1;
              if (underflow_cnt != 8'hFF) underflow_cnt <= underflow_cnt + 1'b1;
            end
          end
          if (!tx_enable) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (consume) begin
            if (pop) begin
              data_i <= head.i;
              data_q <= head.q;
            end else begin
              data_i <= '0;
              data_q <= '0;
              do_tx  <= 1'b0;
              state  <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_iq_feed.sv
// Self-checking bench for tx_iq_feed against a queue-based behavioural model.
module tb_tx_iq_feed;
  localparam int DEPTH   = 16;
  localparam int PREFILL = 8;

  logic        rx_clk = 1'b0;
  logic        rst_ddr = 1'b0;
  logic        tx_enable = 1'b0, flush = 1'b0, wr_en = 1'b0, next_data = 1'b0;
  logic [12:0] wr_i = '0, wr_q = '0;
  logic        wr_full, do_tx, underflow, overflow;
  logic [4:0]  wr_level;
  logic [12:0] data_i, data_q;
  logic [7:0]  underflow_cnt;

  int checks = 0;
  int passes = 0;

  tx_iq_feed #(.DEPTH_LOG2(4), .PREFILL(PREFILL)) dut (
    .rx_clk(rx_clk), .rst_ddr(rst_ddr), .tx_enable(tx_enable), .flush(flush),
    .wr_en(wr_en), .wr_i(wr_i), .wr_q(wr_q), .wr_full(wr_full), .wr_level(wr_level),
    .next_data(next_data), .data_i(data_i), .data_q(data_q), .do_tx(do_tx),
    .underflow(underflow), .overflow(overflow), .underflow_cnt(underflow_cnt)
  );

  always #5 rx_clk = ~rx_clk;

  // Behavioural model: queue of pairs plus the spec-level mode
  typedef struct { logic [12:0] i; logic [12:0] q; } pair_t;
  typedef enum { M_IDLE, M_PREF, M_RUN, M_DRAIN } mode_t;

  pair_t       mq[$];
  mode_t       m_mode;
  logic        m_cur, m_prev, m_dtx, m_uf, m_of;
  logic [12:0] m_di, m_dq;
  int          m_cnt;

  task automatic model_reset();
    mq.delete();
    m_mode = M_IDLE; m_cur = 0; m_prev = 0; m_dtx = 0; m_uf = 0; m_of = 0;
    m_di = 0; m_dq = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit ev, popped;
    int sz;
    pair_t p;
    if (!rst_ddr) begin model_reset(); return; end
    ev = m_cur && !m_prev;
    m_prev = m_cur;
    m_cur  = next_data;
    if (flush) begin
      mq.delete();
      m_mode = M_IDLE; m_dtx = 0; m_di = 0; m_dq = 0; m_uf = 0; m_of = 0; m_cnt = 0;
      return;
    end
    sz = mq.size();
    popped = 0;
    case (m_mode)
      M_IDLE: if (tx_enable) m_mode = M_PREF;
      M_PREF:
        if (!tx_enable) m_mode = M_IDLE;
        else if (sz >= PREFILL) begin
          p = mq.pop_front(); popped = 1;
          m_di = p.i; m_dq = p.q; m_dtx = 1; m_mode = M_RUN;
        end
      M_RUN: begin
        if (ev) begin
          if (sz > 0) begin p = mq.pop_front(); popped = 1; m_di = p.i; m_dq = p.q; end
          else begin m_di = 0; m_dq = 0; m_uf = 1; if (m_cnt < 255) m_cnt++; end
        end
        if (!tx_enable) m_mode = M_DRAIN;
      end
      M_DRAIN:
        if (ev) begin
          if (sz > 0) begin p = mq.pop_front(); popped = 1; m_di = p.i; m_dq = p.q; end
          else begin m_di = 0; m_dq = 0; m_dtx = 0; m_mode = M_IDLE; end
        end
      default: ;
    endcase
    if (wr_en) begin
      if (sz < DEPTH || popped) begin p.i = wr_i; p.q = wr_q; mq.push_back(p); end
      else m_of = 1;
    end
  endtask

  task automatic tick();
    @(posedge rx_clk);
    model_edge();
    #1;
  endtask

  task automatic write_pair(input logic [12:0] i, input logic [12:0] q);
    wr_en = 1; wr_i = i; wr_q = q;
    tick();
    wr_en = 0;
  endtask

  task automatic nd_rise();
    next_data = 1; tick(); tick();
    next_data = 0; tick();
  endtask

  task automatic do_flush();
    flush = 1; tick(); flush = 0;
  endtask

  task automatic wait_do_tx(input string name);
    int n = 0;
    while (!do_tx && n < 20) begin tick(); n++; end
    checks++;
    if (do_tx !== 1'b1) $display("FAIL %s_wait do_tx got %0b want 1 within 20 cycles", name, do_tx);
    else passes++;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge rx_clk);
    #1;
    checks++; if (do_tx !== 1'b0) $display("FAIL reset_do_tx got %0b want 0", do_tx); else passes++;
    checks++; if ({data_i, data_q} !== 26'd0) $display("FAIL reset_data got %h/%h want 0/0", data_i, data_q); else passes++;
    checks++; if ({wr_level, wr_full} !== 6'd0) $display("FAIL reset_level got %0d full %0b want 0/0", wr_level, wr_full); else passes++;
    checks++; if ({underflow, overflow, underflow_cnt} !== 10'd0)
      $display("FAIL reset_flags got uf=%0b of=%0b cnt=%0d want 0", underflow, overflow, underflow_cnt); else passes++;
    @(negedge rx_clk);
    rst_ddr = 1;
    model_reset();
  endtask

  task automatic test_prefill();
    for (int n = 0; n < 8; n++) write_pair(13'(n), 13'(-n));
    checks++; if (do_tx !== 1'b0) $display("FAIL prefill_idle_do_tx got %0b want 0", do_tx); else passes++;
    tx_enable = 1;
    wait_do_tx("prefill");
    checks++; if (data_i !== 13'd0 || data_q !== 13'd0) $display("FAIL prefill_data got %h/%h want 0/0", data_i, data_q); else passes++;
    checks++; if (wr_level !== 5'd7) $display("FAIL prefill_level got %0d want 7", wr_level); else passes++;
  endtask

  task automatic test_consume();
    next_data = 1;
    tick();
    checks++; if (data_i !== 13'd0 || wr_level !== 5'd7)
      $display("FAIL consume_early got data_i=%0d level=%0d want 0/7", data_i, wr_level); else passes++;
    tick();
    checks++; if (data_i !== 13'd1 || data_q !== 13'h1FFF)
      $display("FAIL consume_data got %h/%h want 0001/1fff", data_i, data_q); else passes++;
    checks++; if (wr_level !== 5'd6) $display("FAIL consume_level got %0d want 6", wr_level); else passes++;
    tick(); tick();
    next_data = 0;
    tick(); tick();
    checks++; if (wr_level !== 5'd6 || data_i !== 13'd1 || do_tx !== 1'b1)
      $display("FAIL consume_once got level=%0d data_i=%0d do_tx=%0b want 6/1/1", wr_level, data_i, do_tx); else passes++;
  endtask

  task automatic test_underflow();
    int n = 0;
    while (mq.size() > 0 && n < 20) begin nd_rise(); n++; end
    checks++; if (wr_level !== 5'd0 || data_i !== 13'd7)
      $display("FAIL underflow_empty got level=%0d data_i=%0d want 0/7", wr_level, data_i); else passes++;
    repeat (3) nd_rise();
    checks++; if ({data_i, data_q} !== 26'd0 || do_tx !== 1'b1)
      $display("FAIL underflow_data got %h/%h do_tx=%0b want 0/0/1", data_i, data_q, do_tx); else passes++;
    checks++; if (underflow !== 1'b1 || underflow_cnt !== 8'd3)
      $display("FAIL underflow_cnt got uf=%0b cnt=%0d want 1/3", underflow, underflow_cnt); else passes++;
  endtask

  task automatic test_overflow();
    tx_enable = 0; tick();
    do_flush();
    checks++; if ({underflow, underflow_cnt, do_tx} !== 10'd0)
      $display("FAIL flush_clear got uf=%0b cnt=%0d do_tx=%0b want 0", underflow, underflow_cnt, do_tx); else passes++;
    for (int n = 0; n < DEPTH; n++) write_pair(13'($urandom), 13'($urandom));
    checks++; if (wr_level !== 5'd16 || wr_full !== 1'b1 || overflow !== 1'b0)
      $display("FAIL overflow_fill got level=%0d full=%0b of=%0b want 16/1/0", wr_level, wr_full, overflow); else passes++;
    write_pair(13'h0AA, 13'h155);
    checks++; if (overflow !== 1'b1 || wr_level !== 5'd16)
      $display("FAIL overflow_set got of=%0b level=%0d want 1/16", overflow, wr_level); else passes++;
    tx_enable = 1; tick();
    write_pair(13'h123, 13'h321);
    checks++; if (wr_level !== 5'd16 || do_tx !== 1'b1 || data_i !== m_di || data_q !== m_dq)
      $display("FAIL simul_prefill got level=%0d do_tx=%0b data=%h/%h want 16/1/%h/%h",
               wr_level, do_tx, data_i, data_q, m_di, m_dq); else passes++;
    next_data = 1; tick();
    write_pair(13'h0F0, 13'h00F);
    next_data = 0;
    checks++; if (wr_level !== 5'd16 || wr_full !== 1'b1 || data_i !== m_di || overflow !== 1'b1)
      $display("FAIL simul_run got level=%0d full=%0b data_i=%h of=%0b want 16/1/%h/1",
               wr_level, wr_full, data_i, overflow, m_di); else passes++;
    tick();
  endtask

  task automatic test_drain();
    tx_enable = 0; tick();
    do_flush();
    for (int n = 0; n < 8; n++) write_pair(13'(20 + n), 13'(-20 - n));
    tx_enable = 1;
    wait_do_tx("drain");
    repeat (5) nd_rise();
    checks++; if (wr_level !== 5'd2) $display("FAIL drain_setup_level got %0d want 2", wr_level); else passes++;
    tx_enable = 0; tick();
    nd_rise();
    checks++; if (do_tx !== 1'b1 || data_i !== 13'd26) $display("FAIL drain_pop1 got do_tx=%0b data_i=%0d want 1/26", do_tx, data_i); else passes++;
    nd_rise();
    checks++; if (do_tx !== 1'b1 || data_i !== 13'd27 || wr_level !== 5'd0)
      $display("FAIL drain_pop2 got do_tx=%0b data_i=%0d level=%0d want 1/27/0", do_tx, data_i, wr_level); else passes++;
    nd_rise();
    checks++; if (do_tx !== 1'b0 || {data_i, data_q} !== 26'd0)
      $display("FAIL drain_end got do_tx=%0b data=%h/%h want 0/0/0", do_tx, data_i, data_q); else passes++;
    checks++; if (underflow_cnt !== 8'd0 || underflow !== 1'b0)
      $display("FAIL drain_no_uf got uf=%0b cnt=%0d want 0/0", underflow, underflow_cnt); else passes++;
    nd_rise();
    write_pair(13'd5, 13'd6);
    nd_rise();
    checks++; if (do_tx !== 1'b0 || wr_level !== 5'd1)
      $display("FAIL drain_idle got do_tx=%0b level=%0d want 0/1", do_tx, wr_level); else passes++;
  endtask

  task automatic test_random();
    int pct[4] = '{80, 30, 60, 10};
    do_flush();
    tx_enable = 1;
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 150; c++) begin
        wr_en     = ($urandom_range(0, 99) < pct[ph]);
        wr_i      = 13'($urandom);
        wr_q      = 13'($urandom);
        next_data = ($urandom_range(0, 2) == 0) ? ~next_data : next_data;
        if ($urandom_range(0, 39) == 0) tx_enable = ~tx_enable;
        flush     = ($urandom_range(0, 149) == 0);
        tick();
        checks++;
        if ({do_tx, data_i, data_q, wr_level, wr_full, underflow, overflow, underflow_cnt} !==
            {m_dtx, m_di, m_dq, 5'(mq.size()), mq.size() == DEPTH, m_uf, m_of, 8'(m_cnt)})
          $display("FAIL random_c%0d got tx=%0b d=%h/%h lvl=%0d full=%0b uf=%0b of=%0b cnt=%0d want tx=%0b d=%h/%h lvl=%0d uf=%0b of=%0b cnt=%0d",
                   ph * 150 + c, do_tx, data_i, data_q, wr_level, wr_full, underflow, overflow, underflow_cnt,
                   m_dtx, m_di, m_dq, mq.size(), m_uf, m_of, m_cnt);
        else passes++;
      end
    end
    wr_en = 0; flush = 0; next_data = 0; tx_enable = 0;
    tick(); tick();
  endtask

  task automatic test_reset_mid_run();
    do_flush();
    tx_enable = 1;
    for (int n = 0; n < 8; n++) write_pair(13'(40 + n), 13'(n));
    wait_do_tx("rst_mid");
    #2;
    rst_ddr = 0;
    model_reset();
    #1;
    checks++; if (do_tx !== 1'b0 || wr_level !== 5'd0 || wr_full !== 1'b0)
      $display("FAIL rst_async got do_tx=%0b level=%0d full=%0b want 0/0/0", do_tx, wr_level, wr_full); else passes++;
    checks++; if ({data_i, data_q} !== 26'd0) $display("FAIL rst_async_data got %h/%h want 0/0", data_i, data_q); else passes++;
    @(negedge rx_clk);
    tx_enable = 0;
    rst_ddr = 1;
    tick();
    nd_rise();
    checks++; if (do_tx !== 1'b0 || wr_level !== 5'd0)
      $display("FAIL rst_idle got do_tx=%0b level=%0d want 0/0", do_tx, wr_level); else passes++;
    tx_enable = 1;
    for (int n = 0; n < 8; n++) write_pair(13'(100 + n), 13'(200 + n));
    wait_do_tx("rst_restart");
    checks++; if (data_i !== 13'd100 || data_q !== 13'd200 || wr_level !== 5'd7)
      $display("FAIL rst_restart got data=%0d/%0d level=%0d want 100/200/7", data_i, data_q, wr_level); else passes++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_prefill();
    test_consume();
    test_underflow();
    test_overflow();
    test_drain();
    test_random();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
